// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the encryption datapath.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    localparam byte_t AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix32.sv
// Combinational forward MixColumns of a single 32-bit column (a0 in the top byte).
module mix32
    import aes_pkg::*;
(
    input  word_t col_i,
    output word_t col_o
);

    byte_t a0_s, a1_s, a2_s, a3_s;
    byte_t b0_s, b1_s, b2_s, b3_s;

    assign a0_s = col_i[31:24];
    assign a1_s = col_i[23:16];
    assign a2_s = col_i[15:8];
    assign a3_s = col_i[7:0];

    // 3*x is expressed as xtime(x) ^ x.
    always_comb begin
        b0_s = xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s;
        b1_s = a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s;
        b2_s = a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s;
        b3_s = xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s);
    end

    assign col_o = {b0_s, b1_s, b2_s, b3_s};

endmodule

// File: rtl/mix_cols_iter.sv
// Iterative AES MixColumns engine: one state in, COLS_PER_CYCLE columns mixed per
// clock in place, result held until accepted. Bypass skips the mix at equal latency.
module mix_cols_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bypass,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int N  = (COLS_PER_CYCLE > 0) ? (4 / COLS_PER_CYCLE) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(N - 1);

    if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_param
        $error("mix_cols_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e     fsm_q, fsm_d;
    state_t        data_q, data_d;
    logic          bypass_q, bypass_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0] base_s;
    logic [1:0] col_idx_s [COLS_PER_CYCLE];
    word_t      mix_in_s  [COLS_PER_CYCLE];
    word_t      mix_out_s [COLS_PER_CYCLE];

    // First column of the group selected by the counter.
    always_comb begin
        base_s = 2'(int'(cnt_q) * COLS_PER_CYCLE);
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx_s[g] = base_s + 2'(g);
        assign mix_in_s[g]  = data_q[{col_idx_s[g], 5'd0} +: 32];
        mix32 u_mix32 (
            .col_i (mix_in_s[g]),
            .col_o (mix_out_s[g])
        );
    end

    // State, data, bypass and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= ST_IDLE;
            data_q   <= '0;
            bypass_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            data_q   <= data_d;
            bypass_q <= bypass_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) fsm_d = ST_BUSY;
                else          fsm_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (cnt_q == LAST_GRP) fsm_d = ST_DONE;
                else                   fsm_d = ST_BUSY;
            end
            ST_DONE: begin
                if (out_ready) fsm_d = ST_IDLE;
                else           fsm_d = ST_DONE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Datapath: capture on handshake, mix the selected group in place while busy.
    always_comb begin
        data_d   = data_q;
        bypass_d = bypass_q;
        cnt_d    = cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    bypass_d = in_bypass;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                if (!bypass_q) begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        data_d[{col_idx_s[i], 5'd0} +: 32] = mix_out_s[i];
                    end
                end else begin
                    data_d = data_q;
                end
                if (cnt_q == LAST_GRP) cnt_d = '0;
                else                   cnt_d = cnt_q + CW'(1);
            end
            ST_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Outputs depend only on state (and rst_n keeps in_ready low during reset).
    always_comb begin
        in_ready  = rst_n && (fsm_q == ST_IDLE);
        out_valid = (fsm_q == ST_DONE);
        if (fsm_q == ST_DONE) out_data = data_q;
        else                  out_data = '0;
    end

endmodule

// File: doc/mix_cols_iter.md
Name: mix_cols_iter

Overview:
- Iterative forward AES MixColumns engine for the encryption datapath; counterpart of the decryption-side inverse column mix.
- Accepts one 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE 32-bit columns per clock.
- Returns the mixed state through a second valid/ready handshake.
- A per-transaction bypass flag supports the AES final round, which skips MixColumns, at identical latency.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; anything else is an elaboration error.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input state valid.
in_ready  output  1  engine can accept a state.
in_bypass  input  1  sampled with data; 1 = pass state through unmodified (final round).
in_data  input  128  input state; column c = bits [32c+31:32c].
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_data  output  128  mixed state, same column layout.

Behaviour:
- Byte order within a column: a0=[31:24], a1=[23:16], a2=[15:8], a3=[7:0].
- Column mix in GF(2^8), reduction polynomial 0x11B:
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0).
- Define N = 4/COLS_PER_CYCLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, load the state register and bypass flag, clear the column counter, go to BUSY.
  - BUSY: each cycle, replace columns [cnt*COLS_PER_CYCLE +: COLS_PER_CYCLE] in place with their mixed values (or leave them unchanged if bypass), then increment cnt. When the group just processed is group N-1, go to DONE.
  - DONE: out_valid=1, out_data = state register. On out_ready, go to IDLE.
- Latency: handshake in cycle T gives out_valid first high in cycle T+N+1.
- Throughput: one state per N+2 cycles with out_ready held high. There is no overlap: in_ready=0 in BUSY and DONE.
- out_data and the state register remain stable while out_valid=1 and out_ready=0, for an indefinite stall.
- in_data/in_bypass are ignored when in_ready=0.
- in_bypass is captured only at the input handshake.
- Reset values: in_ready=0 while rst_n=0 and 1 in the first cycle after release. out_valid=0, out_data=0, counter=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately. The partial result is discarded; out_valid is never raised for it.
- Counter width: $clog2(N) bits, min 1. The counter wraps to 0 on BUSY exit.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Package aes_pkg holds:
  - typedefs state_t (logic[127:0]), word_t (logic[31:0]), byte_t (logic[7:0])
  - constant AES_POLY=8'h1B
  - function xtime
- Sub-module mix32: combinational single-column forward mix, word_t in/out. Instantiate it COLS_PER_CYCLE times, indexed by the counter.

Test Plan:
- FIPS-197 vectors: in_data = {db135345, f20a225c, 01010101, c6c6c6c6} (column 3..0), bypass=0 -> out_data = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}. out_valid rises exactly N+1 cycles after the handshake, for each COLS_PER_CYCLE in 1, 2, 4.
- Second vector set: columns d4d4d4d5 and 2d26314c -> d5d5d7d6 and 4d7ebdf8. Compare all results against a bench reference model over 1000 random states.
- Bypass: in_data=0x00112233_44556677_8899aabb_ccddeeff with in_bypass=1 -> identical out_data, same latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout. Release -> one-cycle handshake, then in_ready=1 the next cycle.
- Input ignored when busy: change in_data and pulse in_valid during BUSY -> result unaffected, no second result.
- Reset mid-BUSY (COLS_PER_CYCLE=1, after column 1 is processed): out_valid=0 and out_data=0 immediately. A subsequent fresh transaction produces the correct result.
